// File: rtl/sram_bus_pkg.sv
// Shared types for the SRAM bus arbiter: response kinds, arbitration modes and
// the helper that sizes host index fields.
package sram_bus_pkg;
  typedef enum logic [1:0] {RSP_MEM, RSP_GPIO, RSP_ERR} resp_kind_e;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  function automatic int host_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_bus_arbiter_rr.sv
// Single-grant arbiter: fixed priority (lowest index) or round-robin starting
// at a pointer that moves to one past the last granted host.
module rr_arbiter
  import sram_bus_pkg::*;
#(
  parameter int        NrHosts = 2,
  parameter arb_mode_e ArbMode = ARB_RR,
  localparam int       IdxW    = host_idx_w(NrHosts)
) (
  input  logic               clk_sys,
  input  logic               rst_sys_n,
  input  logic [NrHosts-1:0] req,
  output logic [NrHosts-1:0] gnt,
  output logic               gnt_valid,
  output logic [IdxW-1:0]    gnt_idx
);
  logic [IdxW-1:0] ptr;

  always_comb begin
    int cand;
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NrHosts; k++) begin
      cand = (ArbMode == ARB_RR) ? ((int'(ptr) + k) % NrHosts) : k;
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt_idx    = IdxW'(cand);
        gnt[cand]  = 1'b1;
      end
    end
  end

  // Pointer only moves on a grant, so idle cycles keep the fairness order.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      ptr <= '0;
    end else if (ArbMode == ARB_RR && NrHosts > 1 && gnt_valid) begin
      ptr <= IdxW'((int'(gnt_idx) + 1) % NrHosts);
    end
  end
endmodule

// File: rtl/sram_bus_arbiter.sv
// N-host req/gnt/rvalid interconnect onto one single-port SRAM, with a GPIO
// register and error responses for unmapped addresses.
module sram_bus_arbiter
  import sram_bus_pkg::*;
#(
  parameter int          NrHosts   = 2,
  parameter int          MemSize   = 8192,
  parameter logic [31:0] MemStart  = 32'h0000_0000,
  parameter logic [31:0] GpioAddr  = 32'h0001_0000,
  parameter int          GpioWidth = 4,
  parameter int          ArbMode   = 1
) (
  input  logic                         clk_sys,
  input  logic                         rst_sys_n,
  input  logic [NrHosts-1:0]           host_req_i,
  input  logic [NrHosts-1:0]           host_we_i,
  input  logic [NrHosts*4-1:0]         host_be_i,
  input  logic [NrHosts*32-1:0]        host_addr_i,
  input  logic [NrHosts*32-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]           host_gnt_o,
  output logic [NrHosts-1:0]           host_rvalid_o,
  output logic [NrHosts-1:0]           host_err_o,
  output logic [NrHosts*32-1:0]        host_rdata_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [3:0]                   mem_be_o,
  output logic [$clog2(MemSize/4)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic [GpioWidth-1:0]         gpio_o
);
  localparam int          IdxW    = host_idx_w(NrHosts);
  localparam int          MemHi   = $clog2(MemSize) - 1;
  localparam logic [31:0] MemMask = ~(32'(MemSize) - 32'd1);
  localparam arb_mode_e   Mode    = (ArbMode == 0) ? ARB_FIXED : ARB_RR;

  logic [NrHosts-1:0] arb_req;
  logic               gnt_valid;
  logic [IdxW-1:0]    gnt_idx;
  logic [31:0]        g_addr;
  logic [31:0]        g_wdata;
  logic [3:0]         g_be;
  logic               g_we;
  resp_kind_e         g_kind;

  logic               rsp_valid;
  logic               rsp_we;
  logic [IdxW-1:0]    rsp_idx;
  resp_kind_e         rsp_kind;
  logic [31:0]        rsp_data;
  logic [GpioWidth-1:0] gpio_q;

  // Grants are held off while reset is asserted so every output reads zero.
  assign arb_req = host_req_i & {NrHosts{rst_sys_n}};

  rr_arbiter #(
    .NrHosts (NrHosts),
    .ArbMode (Mode)
  ) u_arb (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .req       (arb_req),
    .gnt       (host_gnt_o),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    g_addr  = host_addr_i[32*gnt_idx +: 32];
    g_wdata = host_wdata_i[32*gnt_idx +: 32];
    g_be    = host_be_i[4*gnt_idx +: 4];
    g_we    = host_we_i[gnt_idx];
    g_kind  = RSP_ERR;
    if ((g_addr & MemMask) == MemStart) begin
      g_kind = RSP_MEM;
    end else if (g_addr[31:2] == GpioAddr[31:2]) begin
      g_kind = RSP_GPIO;
    end
  end

  assign mem_req_o   = gnt_valid && (g_kind == RSP_MEM);
  assign mem_we_o    = mem_req_o && g_we;
  assign mem_be_o    = mem_req_o ? g_be : 4'b0000;
  assign mem_addr_o  = mem_req_o ? g_addr[MemHi:2] : '0;
  assign mem_wdata_o = mem_req_o ? g_wdata : 32'h0;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_idx   <= '0;
      rsp_kind  <= RSP_MEM;
      gpio_q    <= '0;
    end else begin
      rsp_valid <= gnt_valid;
      rsp_we    <= g_we;
      rsp_idx   <= gnt_idx;
      rsp_kind  <= g_kind;
      if (gnt_valid && g_kind == RSP_GPIO && g_we && g_be[0]) begin
        gpio_q <= g_wdata[GpioWidth-1:0];
      end
    end
  end

  assign gpio_o = gpio_q;

  // Writes complete with zero read data regardless of target.
  always_comb begin
    rsp_data = 32'h0;
    if (!rsp_we) begin
      case (rsp_kind)
        RSP_MEM:  rsp_data = mem_rdata_i;
        RSP_GPIO: rsp_data = 32'(gpio_q);
        default:  rsp_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    logic hit;
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    hit           = 1'b0;
    for (int h = 0; h < NrHosts; h++) begin
      hit                   = rsp_valid && (rsp_idx == IdxW'(h));
      host_rvalid_o[h]      = hit;
      host_err_o[h]         = hit && (rsp_kind == RSP_ERR);
      host_rdata_o[32*h +: 32] = hit ? rsp_data : 32'h0;
    end
  end
endmodule
